// File: rtl/bcd_gray_stream.sv
// Registered stream converter between packed BCD digits and per-digit 4-bit Gray code.
// Flags digits outside 0..9 and keeps a saturating count of flagged words.
module bcd_gray_stream #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic [CNT_W-1:0]      err_cnt,
  input  logic                  cnt_clr
);

  logic                out_valid_q, out_valid_d;
  logic [4*DIGITS-1:0] out_data_q, out_data_d;
  logic [DIGITS-1:0]   out_err_q, out_err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic [4*DIGITS-1:0] conv_data;
  logic [DIGITS-1:0]   conv_err;
  logic                accept;

  function automatic logic [3:0] bcd_to_gray(input logic [3:0] d);
    return d ^ (d >> 1);
  endfunction

  function automatic logic [3:0] gray_to_bcd(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Range check is on the BCD side of the conversion in both modes.
  always_comb begin
    conv_data = '0;
    conv_err  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (in_mode) begin
        conv_data[4*i +: 4] = gray_to_bcd(in_data[4*i +: 4]);
        conv_err[i]         = (gray_to_bcd(in_data[4*i +: 4]) > 4'd9);
      end else begin
        conv_data[4*i +: 4] = bcd_to_gray(in_data[4*i +: 4]);
        conv_err[i]         = (in_data[4*i +: 4] > 4'd9);
      end
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_data;
      out_err_d   = conv_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear has priority over a same-cycle increment; the count never wraps.
    if (cnt_clr) begin
      err_cnt_d = '0;
    end else if (accept && (|conv_err) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bcd_gray_stream.sv
// Directed bench for bcd_gray_stream (DIGITS=4, CNT_W=8) with hand-computed expectations.
module tb_bcd_gray_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_err;
  logic [7:0]  err_cnt;
  logic        cnt_clr;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_gray_stream #(
    .DIGITS(4),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .err_cnt  (err_cnt),
    .cnt_clr  (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word, clock it in, sample 1 time unit after the edge.
  task automatic send(input logic mode, input logic [15:0] data);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t stream_v[5];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    #2;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
    check_eq("rst_out_err", {28'd0, out_err}, 32'd0);
    check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_eq("rst_in_ready_empty", {31'd0, in_ready}, 32'd1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // 1. BCD -> Gray
    send(1'b0, 16'h1239);
    check_eq("m0_1239_valid", {31'd0, out_valid}, 32'd1);
    check_eq("m0_1239_data", {16'd0, out_data}, 32'h132D);
    check_eq("m0_1239_err", {28'd0, out_err}, 32'd0);
    check_eq("m0_1239_cnt", {24'd0, err_cnt}, 32'd0);

    // 2. Gray -> BCD and round trips of 0..9
    send(1'b1, 16'h132D);
    check_eq("m1_132d_data", {16'd0, out_data}, 32'h1239);
    check_eq("m1_132d_err", {28'd0, out_err}, 32'd0);
    send(1'b0, 16'h3210);
    check_eq("m0_3210", {16'd0, out_data}, 32'h2310);
    send(1'b1, 16'h2310);
    check_eq("m1_2310", {16'd0, out_data}, 32'h3210);
    send(1'b0, 16'h7654);
    check_eq("m0_7654", {16'd0, out_data}, 32'h4576);
    send(1'b1, 16'h4576);
    check_eq("m1_4576", {16'd0, out_data}, 32'h7654);
    send(1'b0, 16'h9898);
    check_eq("m0_9898", {16'd0, out_data}, 32'hDCDC);
    send(1'b1, 16'hDCDC);
    check_eq("m1_dcdc", {16'd0, out_data}, 32'h9898);
    check_eq("rt_err", {28'd0, out_err}, 32'd0);
    check_eq("rt_cnt", {24'd0, err_cnt}, 32'd0);

    // 3. Out-of-range digits
    send(1'b0, 16'h00A0);
    check_eq("m0_00a0_data", {16'd0, out_data}, 32'h00F0);
    check_eq("m0_00a0_err", {28'd0, out_err}, 32'b0010);
    check_eq("m0_00a0_cnt", {24'd0, err_cnt}, 32'd1);
    send(1'b1, 16'h8000);
    check_eq("m1_8000_data", {16'd0, out_data}, 32'hF000);
    check_eq("m1_8000_err", {28'd0, out_err}, 32'b1000);
    check_eq("m1_8000_cnt", {24'd0, err_cnt}, 32'd2);

    // 4. Backpressure for 5 cycles, then back-to-back drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = 16'h1239;
    #1;
    check_eq("bp_in_ready_pre", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_out_data", {16'd0, out_data}, 32'hF000);
      check_eq("bp_err_cnt", {24'd0, err_cnt}, 32'd2);
    end
    out_ready   = 1'b1;
    stream_v[0] = '{1'b0, 16'h1239, 16'h132D};
    stream_v[1] = '{1'b1, 16'h132D, 16'h1239};
    stream_v[2] = '{1'b0, 16'h3210, 16'h2310};
    stream_v[3] = '{1'b1, 16'h4576, 16'h7654};
    stream_v[4] = '{1'b0, 16'h9898, 16'hDCDC};
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_mode  = stream_v[k].mode;
      in_data  = stream_v[k].din;
      @(posedge clk);
      #1;
      check_eq("b2b_valid", {31'd0, out_valid}, 32'd1);
      check_eq("b2b_data", {16'd0, out_data}, {16'd0, stream_v[k].dout});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("drain_valid", {31'd0, out_valid}, 32'd0);
    check_eq("drain_cnt", {24'd0, err_cnt}, 32'd2);

    // 5. Saturation, clear priority, rejected words
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 16'hFFFF;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("sat_cnt", {24'd0, err_cnt}, 32'd255);
    check_eq("ffff_data", {16'd0, out_data}, 32'h8888);
    check_eq("ffff_err", {28'd0, out_err}, 32'hF);
    @(posedge clk);
    #1;
    check_eq("sat_hold", {24'd0, err_cnt}, 32'd255);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check_eq("clr_wins", {24'd0, err_cnt}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("post_clr_inc", {24'd0, err_cnt}, 32'd1);
    out_ready = 1'b0;
    in_data   = 16'hAAAA;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("reject_no_cnt", {24'd0, err_cnt}, 32'd1);
    check_eq("reject_hold_data", {16'd0, out_data}, 32'h8888);

    // 6. Asynchronous reset mid-stream
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(1'b0, 16'h0123);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_data", {16'd0, out_data}, 32'd0);
    check_eq("arst_err", {28'd0, out_err}, 32'd0);
    check_eq("arst_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_idle", {31'd0, out_valid}, 32'd0);
    send(1'b0, 16'h0009);
    check_eq("post_rst_lat1_valid", {31'd0, out_valid}, 32'd1);
    check_eq("post_rst_lat1_data", {16'd0, out_data}, 32'h000D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
